// File: rtl/iob_native_stream_reader.sv
// -----------------------------------------------------------------------------
// iob_native_stream_reader
//
// IOb-native read initiator that fetches a block of words from a slave and
// streams them out as an AXI-Stream master. The last word carries tlast.
// Only one IOb read is in flight at a time. The returned data passes through a
// single-entry output register on its way to the stream. That register is
// refilled in the same cycle it drains, so a zero-wait slave sustains one word
// every two cycles.
//
// Ports
//   clk_i, cke_i, arst_n_i : clock, clock enable (low freezes all state),
//                            asynchronous active-low reset
//   start_i                : start pulse, only honoured while idle
//   addr_i/nwords_i/incr_i : start byte address, word count, address-increment
//                            enable (0 = fixed address, e.g. a FIFO data CSR)
//   busy_o, done_o         : transfer in progress / one-cycle completion pulse
//   iob_*                  : IOb-native initiator (read-only, wdata/wstrb = 0)
//   axis_*                 : AXI-Stream master
// -----------------------------------------------------------------------------
module iob_native_stream_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_n_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [LEN_W-1:0]      nwords_i,
    input  logic                  incr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  iob_valid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    input  logic                  iob_rvalid_i,
    input  logic [DATA_W-1:0]     iob_rdata_i,
    output logic                  iob_rready_o,
    output logic [DATA_W-1:0]     axis_tdata_o,
    output logic                  axis_tvalid_o,
    input  logic                  axis_tready_i,
    output logic                  axis_tlast_o
);

    localparam int BYTES_PER_WORD = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [LEN_W-1:0]    nwords_q,  nwords_d;
    logic                incr_q,    incr_d;
    logic [LEN_W-1:0]    req_cnt_q, req_cnt_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                valid_q,   valid_d;
    logic [DATA_W-1:0]   tdata_q,   tdata_d;
    logic                tvalid_q,  tvalid_d;
    logic                tlast_q,   tlast_d;

    // The output register can accept new data when it is empty or is being
    // emptied by a stream handshake in this same cycle.
    logic buf_free;
    logic rready_int;
    logic load;
    logic pop;

    assign buf_free   = !tvalid_q || axis_tready_i;
    assign rready_int = (state_q == RESP) && buf_free;
    assign load       = rready_int && iob_rvalid_i;
    assign pop        = tvalid_q && axis_tready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        nwords_d  = nwords_q;
        incr_d    = incr_q;
        req_cnt_d = req_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;

        // Stream beat accepted; a reload below in the same cycle overrides.
        if (pop) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d    = addr_i;
                    nwords_d  = nwords_i;
                    incr_d    = incr_i;
                    req_cnt_d = '0;
                    busy_d    = 1'b1;
                    if (nwords_i == '0) begin
                        // Nothing to read: finish through DRAIN with an empty buffer.
                        state_d = DRAIN;
                    end else begin
                        state_d = REQ;
                        valid_d = 1'b1;
                    end
                end
            end

            REQ: begin
                if (iob_ready_i) begin
                    valid_d   = 1'b0;
                    state_d   = RESP;
                    req_cnt_d = req_cnt_q + 1'b1;
                    if (incr_q) begin
                        // Wraps naturally modulo 2^ADDR_W.
                        addr_d = addr_q + ADDR_W'(BYTES_PER_WORD);
                    end
                end
            end

            RESP: begin
                if (load) begin
                    tdata_d  = iob_rdata_i;
                    tvalid_d = 1'b1;
                    tlast_d  = (req_cnt_q == nwords_q);
                    if (req_cnt_q < nwords_q) begin
                        // Issue the next request while the stream drains this word.
                        state_d = REQ;
                        valid_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Done is raised in the cycle after the final beat is taken.
                if (buf_free) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            nwords_q  <= '0;
            incr_q    <= 1'b0;
            req_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else if (cke_i) begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            nwords_q  <= nwords_d;
            incr_q    <= incr_d;
            req_cnt_q <= req_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign iob_valid_o   = valid_q;
    assign iob_addr_o    = addr_q;
    assign iob_wdata_o   = '0;
    assign iob_wstrb_o   = '0;
    // While frozen the read data could not be captured, so refuse it.
    assign iob_rready_o  = cke_i && rready_int;
    assign axis_tdata_o  = tdata_q;
    assign axis_tvalid_o = tvalid_q;
    assign axis_tlast_o  = tlast_q;

endmodule
